// File: rtl/agm_burst.sv
// agm_burst -- single-transaction burst address generator.
//
// One start/done transaction moves a buffer through three phases:
//   FILL  : strided reads are issued to external memory, one per cycle
//           unless fill_stall holds them off.
//   FLUSH : one cycle that carries the final port A write.
//   DRAIN : the row buffer is read back through the narrower port B,
//           one read per cycle that drain_ready is high.
// Returned memory data is written to BRAM port A one cycle after each
// issue (fixed 1-cycle memory latency), at the index of that issue.
//
// Ports:
//   CLK, rst          clock, synchronous active-high reset
//   start             transaction request, only looked at while idle
//   cfg_mem_base      first external address
//   cfg_mem_stride    external address increment per word
//   cfg_len           words to transfer (clamped to the usable depth)
//   fill_stall        external memory not ready this cycle
//   drain_ready       consumer takes a row-buffer read this cycle
//   mem_rd_en         external read issued (combinational)
//   mem_address       external read address (registered)
//   we_a, ADDR_A      BRAM port A write enable / address (registered)
//   re_b              BRAM port B read enable (combinational)
//   ADDR_B            BRAM port B address (registered)
//   busy              high whenever a transaction is in progress
//   done              one-cycle completion pulse
//
// Build option: define AGM_PINGPONG_EN to split the BRAM into two banks
// selected by the address MSB. A bank bit flips after every completed
// transaction and the length clamp halves to one bank.

module agm_burst #(
   parameter int MEM_AW        = 12,
   parameter int BRAM_AW       = 10,
   parameter int RD_RATIO_LOG2 = 2,
   parameter int LEN_W         = BRAM_AW + 1
) (
   input  logic                             CLK,
   input  logic                             rst,
   input  logic                             start,
   input  logic [MEM_AW-1:0]                cfg_mem_base,
   input  logic [MEM_AW-1:0]                cfg_mem_stride,
   input  logic [LEN_W-1:0]                 cfg_len,
   input  logic                             fill_stall,
   input  logic                             drain_ready,
   output logic                             mem_rd_en,
   output logic [MEM_AW-1:0]                mem_address,
   output logic                             we_a,
   output logic [BRAM_AW-1:0]               ADDR_A,
   output logic                             re_b,
   output logic [BRAM_AW-RD_RATIO_LOG2-1:0] ADDR_B,
   output logic                             busy,
   output logic                             done
);

   // Port B address width and the width of a length/count value that can
   // hold the full depth 2^BRAM_AW.
   localparam int BW = BRAM_AW - RD_RATIO_LOG2;
   localparam int CW = BRAM_AW + 1;

`ifdef AGM_PINGPONG_EN
   // Index bits within one bank; the MSB of each address is the bank bit.
   localparam int IW = BRAM_AW - 1;
   localparam int RW = BW - 1;
`else
   localparam int IW = BRAM_AW;
   localparam int RW = BW;
`endif

   localparam logic [CW-1:0] MAX_LEN  = CW'(1) << IW;
   localparam logic [CW-1:0] RATIO_M1 = CW'((1 << RD_RATIO_LOG2) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [MEM_AW-1:0] mem_addr_reg;
   logic [MEM_AW-1:0] stride_reg;
   logic [IW-1:0]     idx_reg;        // index of the next issue
   logic [IW-1:0]     len_last_reg;   // L-1
   logic              we_a_reg;
   logic [IW-1:0]     addr_a_reg;
   logic [RW-1:0]     rd_idx_reg;
   logic [RW-1:0]     rd_last_reg;    // R-1
   logic [CW-1:0]     len_clamp;
   logic [CW-1:0]     rd_cnt;
   logic              accept;

   // Effective length and the port B read count ceil(L / 2^RD_RATIO_LOG2).
   // The sum cannot overflow CW bits because L never exceeds 2^IW.
   always_comb begin
      len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ? MAX_LEN : CW'(cfg_len);
      rd_cnt    = (len_clamp + RATIO_M1) >> RD_RATIO_LOG2;
   end

   assign accept = (state_reg == S_IDLE) && start;

   // State register
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_next = state_reg;
      mem_rd_en  = 1'b0;
      re_b       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = (len_clamp == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            mem_rd_en = !fill_stall;
            if (!fill_stall && (idx_reg == len_last_reg)) begin
               state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_next = S_DRAIN;
         end
         S_DRAIN: begin
            re_b = drain_ready;
            if (drain_ready && (rd_idx_reg == rd_last_reg)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: address generation and the one-cycle write pipeline
   always_ff @(posedge CLK) begin
      if (rst) begin
         mem_addr_reg <= '0;
         stride_reg   <= '0;
         idx_reg      <= '0;
         len_last_reg <= '0;
         we_a_reg     <= 1'b0;
         addr_a_reg   <= '0;
         rd_idx_reg   <= '0;
         rd_last_reg  <= '0;
      end else begin
         // Data returns one cycle after the issue, so the write strobe and
         // its address are simply the issue strobe and index delayed.
         we_a_reg <= mem_rd_en;
         if (accept) begin
            mem_addr_reg <= cfg_mem_base;
            stride_reg   <= cfg_mem_stride;
            idx_reg      <= '0;
            // Only meaningful when L > 0; an empty transaction skips FILL.
            len_last_reg <= IW'(len_clamp - 1'b1);
            rd_last_reg  <= RW'(rd_cnt - 1'b1);
         end
         if (mem_rd_en) begin
            mem_addr_reg <= mem_addr_reg + stride_reg;
            idx_reg      <= idx_reg + 1'b1;
            addr_a_reg   <= idx_reg;
         end
         if (state_reg == S_FLUSH) begin
            rd_idx_reg <= '0;
         end
         if (re_b) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
         end
      end
   end

   assign mem_address = mem_addr_reg;
   assign we_a        = we_a_reg;

`ifdef AGM_PINGPONG_EN
   // Bank of the transaction in progress; flips as each one completes.
   logic bank_reg;

   always_ff @(posedge CLK) begin
      if (rst) begin
         bank_reg <= 1'b0;
      end else if (state_reg == S_DONE) begin
         bank_reg <= ~bank_reg;
      end
   end

   assign ADDR_A = {bank_reg, addr_a_reg};
   assign ADDR_B = {bank_reg, rd_idx_reg};
`else
   assign ADDR_A = addr_a_reg;
   assign ADDR_B = rd_idx_reg;
`endif

endmodule

// File: doc/agm_burst.md
Name: agm_burst

Overview:
- Parametrised successor to the fixed three-counter address generator.
- One FSM sequences a complete buffer transaction:
  - strided reads from external memory,
  - writes of the returned data into BRAM port A (full width),
  - reads of the row buffer through BRAM port B, which is narrower in depth by 2^RD_RATIO_LOG2.
- Sits between the external-memory reader and the row-buffer consumer. Replaces the three free-running enable-driven counters with one start/done transaction.

Parameters:
- MEM_AW, 12: external memory address width.
- BRAM_AW, 10: port A address width. BRAM depth is 2^BRAM_AW.
- RD_RATIO_LOG2, 2: log2 of port B/port A data-width ratio. Port B address width is BRAM_AW-RD_RATIO_LOG2.
- LEN_W, BRAM_AW+1: width of the transfer length field.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transaction request; sampled only in IDLE.
- cfg_mem_base  in  MEM_AW  first external address.
- cfg_mem_stride  in  MEM_AW  address increment per word.
- cfg_len  in  LEN_W  words to transfer.
- fill_stall  in  1  external memory not ready; blocks issue this cycle.
- drain_ready  in  1  consumer accepts a row-buffer read this cycle.
- mem_rd_en  out  1  external read issued (combinational).
- mem_address  out  MEM_AW  external read address (registered).
- we_a  out  1  BRAM port A write enable (registered).
- ADDR_A  out  BRAM_AW  BRAM write address (registered).
- re_b  out  1  BRAM port B read enable (combinational).
- ADDR_B  out  BRAM_AW-RD_RATIO_LOG2  row-buffer read address (registered).
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset:
  - state IDLE.
  - mem_address, ADDR_A, ADDR_B, we_a, done, busy all 0.
  - mem_rd_en and re_b evaluate to 0.
  - rst mid-transaction aborts immediately. Nothing resumes.
- States: IDLE, FILL, FLUSH, DRAIN, DONE.
- IDLE:
  - On start: latch cfg_* and go to FILL. mem_address <= cfg_mem_base; issue index <= 0.
  - Effective length L = min(cfg_len, 2^BRAM_AW).
  - If L == 0: go straight to DONE. No reads or writes occur.
- FILL:
  - mem_rd_en = !fill_stall.
  - On each accepted issue:
    - mem_address <= mem_address + stride (running sum, modulo 2^MEM_AW, no multiplier);
    - index increments.
  - With fill_stall high, mem_address and index hold.
  - After the issue with index == L-1, go to FLUSH.
- Write pipeline (fixed 1-cycle memory latency):
  - we_a(t+1) = mem_rd_en(t).
  - ADDR_A(t+1) = index(t), truncated to BRAM_AW.
  - fill_stall does not affect writes already in flight.
- FLUSH: exactly one cycle, carrying the final we_a. Then DRAIN with ADDR_B = 0.
- DRAIN:
  - re_b = drain_ready.
  - ADDR_B increments on each re_b.
  - Read count R = ceil(L / 2^RD_RATIO_LOG2).
  - After the read at ADDR_B == R-1, go to DONE.
- DONE: done = 1 for exactly one cycle, busy still 1. Then IDLE.
- start while busy is ignored. cfg_* changes after start are ignored.
- Wrap-around: mem_address wraps silently. L == 2^BRAM_AW writes ADDR_A 0..2^BRAM_AW-1 with no overflow.

Optional Feature:
- Macro: AGM_PINGPONG_EN.
- When defined:
  - BRAM is split into two banks using the MSB of ADDR_A and ADDR_B.
  - A bank bit, reset 0, selects the bank being filled and drained in the current transaction. It toggles on each done.
  - L is clamped to 2^(BRAM_AW-1).
  - Lower address bits behave as above.
- When undefined: no bank bit; full depth is used; the clamp is 2^BRAM_AW.

Test Plan:
- base=0x100, stride=1, len=8, no stall, ratio 4 -> mem_address 0x100..0x107 on 8 consecutive mem_rd_en cycles; we_a on 8 cycles lagging by 1 with ADDR_A 0..7; FLUSH; ADDR_B 0,1; done pulses one cycle after the second re_b.
- base=0xFFE, stride=3, len=4 -> mem_address 0xFFE, 0x001, 0x004, 0x007 (wrap); ADDR_A 0..3.
- len=5, fill_stall high on the 2nd and 3rd FILL cycles -> no issue and address held during the stall; exactly 5 writes total; R=2 (ADDR_B 0,1).
- len=0 -> done pulses the cycle after start; mem_rd_en, we_a, re_b never assert; start while busy produces no second transaction.
- rst asserted mid-FILL -> next cycle all outputs 0, busy 0; a new start resumes nothing and begins at ADDR_A 0 with the new cfg_mem_base.
- AGM_PINGPONG_EN, two back-to-back len=4 runs -> first run writes ADDR_A 0x000-0x003 and reads ADDR_B MSB 0; second run writes 0x200-0x203 and reads with ADDR_B MSB 1; len=1024 clamps to 512 writes.
